// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and decode helpers used by the decode stage and its register file.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] CMOVXX = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  // "No register" ID; never written, never matched by forwarding
  localparam logic [3:0] RNONE  = 4'hF;

  // Status codes
  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;

  // Register IDs an instruction reads and writes
  typedef struct packed {
    logic [3:0] srcA;
    logic [3:0] srcB;
    logic [3:0] dstE;
    logic [3:0] dstM;
  } reg_ids_t;

  // Map an instruction to its source/destination register IDs
  function automatic reg_ids_t decode_ids(input logic [3:0] icode,
                                          input logic [3:0] rA,
                                          input logic [3:0] rB,
                                          input logic [3:0] sp);
    reg_ids_t ids;
    ids = '{srcA: RNONE, srcB: RNONE, dstE: RNONE, dstM: RNONE};
    case (icode)
      CMOVXX: begin ids.srcA = rA; ids.dstE = rB; end
      IRMOVQ: begin ids.dstE = rB; end
      RMMOVQ: begin ids.srcA = rA; ids.srcB = rB; end
      MRMOVQ: begin ids.srcB = rB; ids.dstM = rA; end
      OPQ:    begin ids.srcA = rA; ids.srcB = rB; ids.dstE = rB; end
      CALL:   begin ids.srcB = sp; ids.dstE = sp; end
      RET:    begin ids.srcA = sp; ids.srcB = sp; ids.dstE = sp; end
      PUSHQ:  begin ids.srcA = rA; ids.srcB = sp; ids.dstE = sp; end
      POPQ:   begin ids.srcA = sp; ids.srcB = sp; ids.dstE = sp; ids.dstM = rA; end
      default: ;
    endcase
    return ids;
  endfunction

  // Instructions whose result only appears after the memory stage
  function automatic logic is_load(input logic [3:0] icode);
    return (icode == MRMOVQ) || (icode == POPQ);
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// Architectural register file: two asynchronous read ports, two write ports, dstM wins on collision.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int              XLEN    = 64,
  parameter int              NREG    = 15,
  parameter int              SP_ID   = 4,
  parameter logic [XLEN-1:0] SP_INIT = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      srcA_i,
  input  logic [3:0]      srcB_i,
  output logic [XLEN-1:0] rdA_o,
  output logic [XLEN-1:0] rdB_o,
  input  logic [3:0]      dstM_i,
  input  logic [XLEN-1:0] valM_i,
  input  logic [3:0]      dstE_i,
  input  logic [XLEN-1:0] valE_i
);

  logic [XLEN-1:0] regs_q [NREG];

  // Reset loads SP_INIT into the stack pointer; otherwise write-back with dstM taking priority
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= (i == SP_ID) ? SP_INIT : '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (dstM_i != RNONE && dstM_i == 4'(i)) begin
          regs_q[i] <= valM_i;
        end else if (dstE_i != RNONE && dstE_i == 4'(i)) begin
          regs_q[i] <= valE_i;
        end
      end
    end
  end

  // Asynchronous reads; RNONE and unimplemented IDs read as zero
  always_comb begin
    rdA_o = '0;
    rdB_o = '0;
    for (int i = 0; i < NREG; i++) begin
      if (srcA_i == 4'(i)) rdA_o = regs_q[i];
      if (srcB_i == 4'(i)) rdB_o = regs_q[i];
    end
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Y86-64 decode stage: register IDs, operand forwarding, load/use stall and the D->E pipeline register.
module decode_stage_pipe
  import y86_pkg::*;
#(
  parameter int              XLEN    = 64,
  parameter int              NREG    = 15,
  parameter int              SP_ID   = 4,
  parameter logic [XLEN-1:0] SP_INIT = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      D_stat,
  input  logic [3:0]      D_icode,
  input  logic [3:0]      D_ifun,
  input  logic [3:0]      D_rA,
  input  logic [3:0]      D_rB,
  input  logic [XLEN-1:0] D_valC,
  input  logic [XLEN-1:0] D_valP,
  input  logic [3:0]      e_dstE,
  input  logic [XLEN-1:0] e_valE,
  input  logic [3:0]      M_dstM,
  input  logic [XLEN-1:0] m_valM,
  input  logic [3:0]      M_dstE,
  input  logic [XLEN-1:0] M_valE,
  input  logic [3:0]      W_dstM,
  input  logic [XLEN-1:0] W_valM,
  input  logic [3:0]      W_dstE,
  input  logic [XLEN-1:0] W_valE,
  input  logic [3:0]      E_icode_q,
  input  logic [3:0]      E_dstM_q,
  input  logic            flush,
  output logic            d_stall,
  output logic [2:0]      E_stat,
  output logic [3:0]      E_icode,
  output logic [3:0]      E_ifun,
  output logic [XLEN-1:0] E_valC,
  output logic [XLEN-1:0] E_valA,
  output logic [XLEN-1:0] E_valB,
  output logic [3:0]      E_dstE,
  output logic [3:0]      E_dstM,
  output logic [3:0]      E_srcA,
  output logic [3:0]      E_srcB
);

  reg_ids_t        ids;
  logic [XLEN-1:0] rfA, rfB;
  logic [XLEN-1:0] valA, valB;

  logic [2:0]      stat_q,  stat_d;
  logic [3:0]      icode_q, icode_d;
  logic [3:0]      ifun_q,  ifun_d;
  logic [XLEN-1:0] valC_q,  valC_d;
  logic [XLEN-1:0] valA_q,  valA_d;
  logic [XLEN-1:0] valB_q,  valB_d;
  logic [3:0]      dstE_q,  dstE_d;
  logic [3:0]      dstM_q,  dstM_d;
  logic [3:0]      srcA_q,  srcA_d;
  logic [3:0]      srcB_q,  srcB_d;

  assign ids = decode_ids(D_icode, D_rA, D_rB, 4'(SP_ID));

  y86_regfile #(
    .XLEN   (XLEN),
    .NREG   (NREG),
    .SP_ID  (SP_ID),
    .SP_INIT(SP_INIT)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .srcA_i(ids.srcA),
    .srcB_i(ids.srcB),
    .rdA_o (rfA),
    .rdB_o (rfB),
    .dstM_i(W_dstM),
    .valM_i(W_valM),
    .dstE_i(W_dstE),
    .valE_i(W_valE)
  );

  // Operand selection: youngest in-flight producer wins; call/jXX carry valP in valA
  always_comb begin
    valA = rfA;
    if (D_icode == CALL || D_icode == JXX)         valA = D_valP;
    else if (ids.srcA != RNONE && ids.srcA == e_dstE) valA = e_valE;
    else if (ids.srcA != RNONE && ids.srcA == M_dstM) valA = m_valM;
    else if (ids.srcA != RNONE && ids.srcA == M_dstE) valA = M_valE;
    else if (ids.srcA != RNONE && ids.srcA == W_dstM) valA = W_valM;
    else if (ids.srcA != RNONE && ids.srcA == W_dstE) valA = W_valE;

    valB = rfB;
    if (ids.srcB != RNONE && ids.srcB == e_dstE)      valB = e_valE;
    else if (ids.srcB != RNONE && ids.srcB == M_dstM) valB = m_valM;
    else if (ids.srcB != RNONE && ids.srcB == M_dstE) valB = M_valE;
    else if (ids.srcB != RNONE && ids.srcB == W_dstM) valB = W_valM;
    else if (ids.srcB != RNONE && ids.srcB == W_dstE) valB = W_valE;
  end

  // Load/use hazard: a load in E produces a value this instruction needs now
  always_comb begin
    d_stall = is_load(E_icode_q) && (E_dstM_q != RNONE) &&
              ((E_dstM_q == ids.srcA) || (E_dstM_q == ids.srcB));
  end

  // Next E contents: a bubble on flush or stall, otherwise the decoded instruction
  always_comb begin
    stat_d  = D_stat;
    icode_d = D_icode;
    ifun_d  = D_ifun;
    valC_d  = D_valC;
    valA_d  = valA;
    valB_d  = valB;
    dstE_d  = ids.dstE;
    dstM_d  = ids.dstM;
    srcA_d  = ids.srcA;
    srcB_d  = ids.srcB;
    if (flush || d_stall) begin
      stat_d  = AOK;
      icode_d = NOP;
      ifun_d  = 4'h0;
      valC_d  = '0;
      valA_d  = '0;
      valB_d  = '0;
      dstE_d  = RNONE;
      dstM_d  = RNONE;
      srcA_d  = RNONE;
      srcB_d  = RNONE;
    end
  end

  // D->E pipeline register; reset loads the same bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q  <= AOK;
      icode_q <= NOP;
      ifun_q  <= 4'h0;
      valC_q  <= '0;
      valA_q  <= '0;
      valB_q  <= '0;
      dstE_q  <= RNONE;
      dstM_q  <= RNONE;
      srcA_q  <= RNONE;
      srcB_q  <= RNONE;
    end else begin
      stat_q  <= stat_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      valC_q  <= valC_d;
      valA_q  <= valA_d;
      valB_q  <= valB_d;
      dstE_q  <= dstE_d;
      dstM_q  <= dstM_d;
      srcA_q  <= srcA_d;
      srcB_q  <= srcB_d;
    end
  end

  assign E_stat  = stat_q;
  assign E_icode = icode_q;
  assign E_ifun  = ifun_q;
  assign E_valC  = valC_q;
  assign E_valA  = valA_q;
  assign E_valB  = valB_q;
  assign E_dstE  = dstE_q;
  assign E_dstM  = dstM_q;
  assign E_srcA  = srcA_q;
  assign E_srcB  = srcB_q;

endmodule
